// File: rtl/solver_scheduler_if.sv
// Job-header, limb-beat and result streams between a job source and solver_scheduler.
// The master side offers jobs and limb beats and consumes results; the slave side is the scheduler.
interface solver_scheduler_if #(
  parameter int unsigned LIMB_INDEX_BITS = 6,
  parameter int unsigned ITER_BITS       = 16,
  parameter int unsigned TAG_BITS        = 16,
  parameter int unsigned SEL_BITS        = 2
);
  logic                       job_valid;
  logic                       job_ready;
  logic [TAG_BITS-1:0]        job_tag;
  logic [LIMB_INDEX_BITS-1:0] job_num_limbs;
  logic [ITER_BITS-1:0]       job_iter_lim;
  logic                       limb_valid;
  logic                       limb_ready;
  logic                       res_valid;
  logic                       res_ready;
  logic [TAG_BITS-1:0]        res_tag;
  logic [ITER_BITS-1:0]       res_iter;
  logic [SEL_BITS-1:0]        res_solver;

  modport master (
    output job_valid, job_tag, job_num_limbs, job_iter_lim, limb_valid, res_ready,
    input  job_ready, limb_ready, res_valid, res_tag, res_iter, res_solver
  );

  modport slave (
    input  job_valid, job_tag, job_num_limbs, job_iter_lim, limb_valid, res_ready,
    output job_ready, limb_ready, res_valid, res_tag, res_iter, res_solver
  );
endinterface

// File: rtl/solver_scheduler.sv
// Dispatches point jobs to the lowest idle solver core and returns results round-robin.
// Limb data itself is broadcast elsewhere; this block drives only per-core strobes, config and start.
module solver_scheduler #(
  parameter int unsigned NUM_SOLVERS     = 4,
  parameter int unsigned LIMB_INDEX_BITS = 6,
  parameter int unsigned ITER_BITS       = 16,
  parameter int unsigned TAG_BITS        = 16,
  parameter int unsigned SEL_BITS        = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1
) (
  input  logic                             clock,
  input  logic                             reset,
  solver_scheduler_if.slave                bus,
  output logic [NUM_SOLVERS-1:0]           slv_wr_real_en,
  output logic [NUM_SOLVERS-1:0]           slv_wr_imag_en,
  output logic [LIMB_INDEX_BITS-1:0]       slv_wr_ind,
  output logic [NUM_SOLVERS-1:0]           slv_wr_num_limbs_en,
  output logic [NUM_SOLVERS-1:0]           slv_wr_iter_lim_en,
  output logic [LIMB_INDEX_BITS-1:0]       slv_num_limbs,
  output logic [ITER_BITS-1:0]             slv_iter_lim,
  output logic [NUM_SOLVERS-1:0]           slv_start,
  input  logic [NUM_SOLVERS-1:0]           slv_out_ready,
  input  logic [NUM_SOLVERS*ITER_BITS-1:0] slv_iter_count
);

  localparam int unsigned LAST_SEL = NUM_SOLVERS - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_RE,
    S_LOAD_IM,
    S_CONFIG,
    S_START
  } state_t;

  state_t                     state_q, state_d;
  logic [SEL_BITS-1:0]        sel_q;
  logic [LIMB_INDEX_BITS-1:0] num_limbs_q;
  logic [LIMB_INDEX_BITS-1:0] cnt_q;
  logic [ITER_BITS-1:0]       iter_lim_q;
  logic [TAG_BITS-1:0]        tag_q [NUM_SOLVERS];
  logic [NUM_SOLVERS-1:0]     busy_q;
  logic [NUM_SOLVERS-1:0]     armed_q;
  logic [SEL_BITS-1:0]        rr_q;

  logic                       res_valid_q;
  logic [TAG_BITS-1:0]        res_tag_q;
  logic [ITER_BITS-1:0]       res_iter_q;
  logic [SEL_BITS-1:0]        res_solver_q;

  logic                       any_free;
  logic [SEL_BITS-1:0]        free_sel;
  logic [NUM_SOLVERS-1:0]     sel_oh;
  logic                       accept;
  logic                       beat;
  logic                       last_beat;

  logic [NUM_SOLVERS-1:0]     done;
  logic                       cap_any;
  logic                       cap_fire;
  logic [SEL_BITS-1:0]        cap_sel;
  logic [SEL_BITS-1:0]        scan_idx;
  logic [NUM_SOLVERS-1:0]     cap_oh;
  logic [SEL_BITS-1:0]        rr_next;
  logic [ITER_BITS-1:0]       iter_arr [NUM_SOLVERS];

  // Lowest-indexed idle core
  always_comb begin
    any_free = ~&busy_q;
    free_sel = '0;
    for (int k = int'(NUM_SOLVERS) - 1; k >= 0; k--) begin
      if (!busy_q[k]) free_sel = SEL_BITS'(k);
    end
  end

  assign sel_oh    = NUM_SOLVERS'(1) << sel_q;
  assign last_beat = (cnt_q == num_limbs_q - LIMB_INDEX_BITS'(1));

  // Dispatch FSM: next state and per-state strobes
  always_comb begin
    state_d             = state_q;
    accept              = 1'b0;
    beat                = 1'b0;
    bus.job_ready       = 1'b0;
    bus.limb_ready      = 1'b0;
    slv_wr_real_en      = '0;
    slv_wr_imag_en      = '0;
    slv_wr_ind          = '0;
    slv_wr_num_limbs_en = '0;
    slv_wr_iter_lim_en  = '0;
    slv_num_limbs       = '0;
    slv_iter_lim        = '0;
    slv_start           = '0;
    unique case (state_q)
      S_IDLE: begin
        bus.job_ready = any_free;
        if (bus.job_valid && any_free) begin
          accept  = 1'b1;
          state_d = (bus.job_num_limbs == '0) ? S_CONFIG : S_LOAD_RE;
        end
      end
      S_LOAD_RE: begin
        bus.limb_ready = 1'b1;
        slv_wr_ind     = cnt_q;
        beat           = bus.limb_valid;
        slv_wr_real_en = bus.limb_valid ? sel_oh : '0;
        if (beat && last_beat) state_d = S_LOAD_IM;
      end
      S_LOAD_IM: begin
        bus.limb_ready = 1'b1;
        slv_wr_ind     = cnt_q;
        beat           = bus.limb_valid;
        slv_wr_imag_en = bus.limb_valid ? sel_oh : '0;
        if (beat && last_beat) state_d = S_CONFIG;
      end
      // The core samples its limb count on the start cycle, so config lands one cycle earlier.
      S_CONFIG: begin
        slv_wr_num_limbs_en = sel_oh;
        slv_wr_iter_lim_en  = sel_oh;
        slv_num_limbs       = num_limbs_q;
        slv_iter_lim        = iter_lim_q;
        state_d             = S_START;
      end
      S_START: begin
        slv_start = sel_oh;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Latched job header and beat counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_q       <= '0;
      num_limbs_q <= '0;
      iter_lim_q  <= '0;
      cnt_q       <= '0;
    end else if (accept) begin
      sel_q       <= free_sel;
      num_limbs_q <= bus.job_num_limbs;
      iter_lim_q  <= bus.job_iter_lim;
      cnt_q       <= '0;
    end else if (beat) begin
      cnt_q <= last_beat ? '0 : cnt_q + LIMB_INDEX_BITS'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(NUM_SOLVERS); k++) tag_q[k] <= '0;
    end else if (accept) begin
      tag_q[free_sel] <= bus.job_tag;
    end
  end

  always_comb begin
    for (int k = 0; k < int'(NUM_SOLVERS); k++) begin
      iter_arr[k] = slv_iter_count[k*ITER_BITS +: ITER_BITS];
    end
  end

  // Armed masks a done level left over from the core's previous job until it is restarted.
  always_comb begin
    done     = armed_q & slv_out_ready;
    cap_any  = |done;
    cap_sel  = '0;
    scan_idx = '0;
    for (int off = int'(NUM_SOLVERS) - 1; off >= 0; off--) begin
      scan_idx = SEL_BITS'((int'(rr_q) + off) % int'(NUM_SOLVERS));
      if (done[scan_idx]) cap_sel = scan_idx;
    end
    cap_fire = cap_any && (!res_valid_q || bus.res_ready);
    cap_oh   = cap_fire ? (NUM_SOLVERS'(1) << cap_sel) : '0;
    rr_next  = (cap_sel == SEL_BITS'(LAST_SEL)) ? '0 : cap_sel + SEL_BITS'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q  <= '0;
      armed_q <= '0;
    end else begin
      busy_q  <= (busy_q  | slv_start) & ~cap_oh;
      armed_q <= (armed_q | slv_start) & ~cap_oh;
    end
  end

  // Result register; held stable while the consumer stalls
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_valid_q  <= 1'b0;
      res_tag_q    <= '0;
      res_iter_q   <= '0;
      res_solver_q <= '0;
      rr_q         <= '0;
    end else if (cap_fire) begin
      res_valid_q  <= 1'b1;
      res_tag_q    <= tag_q[cap_sel];
      res_iter_q   <= iter_arr[cap_sel];
      res_solver_q <= cap_sel;
      rr_q         <= rr_next;
    end else if (bus.res_ready) begin
      res_valid_q  <= 1'b0;
    end
  end

  assign bus.res_valid  = res_valid_q;
  assign bus.res_tag    = res_tag_q;
  assign bus.res_iter   = res_iter_q;
  assign bus.res_solver = res_solver_q;

endmodule

// File: tb/tb_solver_scheduler.sv
// Directed bench for solver_scheduler: the driver issues jobs and core completions,
// a monitor pops expected results from a scoreboard queue on every result handshake.
module tb_solver_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned LB = 6;
  localparam int unsigned IB = 16;
  localparam int unsigned TB = 16;
  localparam int unsigned SB = 2;

  typedef struct packed {
    logic [15:0] tag;
    logic [15:0] iter;
    logic [1:0]  core;
  } exp_t;

  logic            clock;
  logic            reset;
  logic [N-1:0]    slv_wr_real_en;
  logic [N-1:0]    slv_wr_imag_en;
  logic [LB-1:0]   slv_wr_ind;
  logic [N-1:0]    slv_wr_num_limbs_en;
  logic [N-1:0]    slv_wr_iter_lim_en;
  logic [LB-1:0]   slv_num_limbs;
  logic [IB-1:0]   slv_iter_lim;
  logic [N-1:0]    slv_start;
  logic [N-1:0]    slv_out_ready;
  logic [N*IB-1:0] slv_iter_count;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  solver_scheduler_if #(.LIMB_INDEX_BITS(LB), .ITER_BITS(IB), .TAG_BITS(TB), .SEL_BITS(SB)) bus ();

  solver_scheduler #(
    .NUM_SOLVERS(N), .LIMB_INDEX_BITS(LB), .ITER_BITS(IB), .TAG_BITS(TB), .SEL_BITS(SB)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .bus                 (bus),
    .slv_wr_real_en      (slv_wr_real_en),
    .slv_wr_imag_en      (slv_wr_imag_en),
    .slv_wr_ind          (slv_wr_ind),
    .slv_wr_num_limbs_en (slv_wr_num_limbs_en),
    .slv_wr_iter_lim_en  (slv_wr_iter_lim_en),
    .slv_num_limbs       (slv_num_limbs),
    .slv_iter_lim        (slv_iter_lim),
    .slv_start           (slv_start),
    .slv_out_ready       (slv_out_ready),
    .slv_iter_count      (slv_iter_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish by 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] all_strobes();
    return 32'({slv_wr_real_en, slv_wr_imag_en, slv_wr_num_limbs_en, slv_wr_iter_lim_en, slv_start});
  endfunction

  // Models a core completing: count appears with its done level; the result is expected in order.
  task automatic finish_core(input int core, input logic [15:0] cnt, input logic [15:0] tag);
    exp_t e;
    slv_iter_count[core*16 +: 16] = cnt;
    slv_out_ready[core]           = 1'b1;
    e.tag  = tag;
    e.iter = cnt;
    e.core = 2'(core);
    exp_q.push_back(e);
  endtask

  // Offers a header, streams n real and n imag beats, and checks every strobe on the way.
  task automatic send_job(input logic [15:0] tag, input logic [5:0] n, input logic [15:0] lim,
                          input int core);
    logic [3:0] oh;
    int         waited;
    oh                = 4'b0001 << core;
    bus.job_valid     = 1'b1;
    bus.job_tag       = tag;
    bus.job_num_limbs = n;
    bus.job_iter_lim  = lim;
    waited            = 0;
    @(negedge clock);
    while (!bus.job_ready && waited < 200) begin
      cyc();
      @(negedge clock);
      waited++;
    end
    check("job_accept", 32'(bus.job_ready), 1);
    cyc();
    bus.job_valid  = 1'b0;
    bus.limb_valid = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      @(negedge clock);
      check("real_en", 32'(slv_wr_real_en), 32'(oh));
      check("real_ind", 32'(slv_wr_ind), 32'(i));
      check("real_limb_ready", 32'(bus.limb_ready), 1);
      cyc();
    end
    for (int i = 0; i < int'(n); i++) begin
      @(negedge clock);
      check("imag_en", 32'(slv_wr_imag_en), 32'(oh));
      check("imag_ind", 32'(slv_wr_ind), 32'(i));
      cyc();
    end
    bus.limb_valid = 1'b0;
    @(negedge clock);
    check("cfg_strobes", 32'({slv_wr_num_limbs_en, slv_wr_iter_lim_en, slv_start}), 32'({oh, oh, 4'b0000}));
    check("cfg_num_limbs", 32'(slv_num_limbs), 32'(n));
    check("cfg_iter_lim", 32'(slv_iter_lim), 32'(lim));
    check("cfg_limb_ready", 32'(bus.limb_ready), 0);
    cyc();
    @(negedge clock);
    check("start", all_strobes(), 32'(oh));
    cyc();
    // the core's done level falls at the edge where it is started
    slv_out_ready[core] = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (!reset && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got tag 0x%0h solver %0d want no result at %0t",
                 bus.res_tag, bus.res_solver, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_tag", 32'(bus.res_tag), 32'(mon_e.tag));
        check("res_iter", 32'(bus.res_iter), 32'(mon_e.iter));
        check("res_solver", 32'(bus.res_solver), 32'(mon_e.core));
      end
    end
  end

  initial begin
    int w;
    reset             = 1'b1;
    bus.job_valid     = 1'b0;
    bus.job_tag       = '0;
    bus.job_num_limbs = '0;
    bus.job_iter_lim  = '0;
    bus.limb_valid    = 1'b0;
    bus.res_ready     = 1'b1;
    slv_out_ready     = '0;
    slv_iter_count    = '0;

    @(negedge clock);
    check("rst_job_ready", 32'(bus.job_ready), 1);
    check("rst_limb_ready", 32'(bus.limb_ready), 0);
    check("rst_strobes", all_strobes(), 0);
    check("rst_res", 32'({bus.res_valid, bus.res_solver, bus.res_iter}), 0);
    check("rst_res_tag", 32'(bus.res_tag), 0);
    cyc();
    reset = 1'b0;

    // Single job, one-cycle done-to-result latency
    send_job(16'h0A5A, 6'd2, 16'd100, 0);
    finish_core(0, 16'd37, 16'h0A5A);
    @(negedge clock);
    check("lat_cycle0", 32'(bus.res_valid), 0);
    cyc();
    @(negedge clock);
    check("lat_cycle1", 32'(bus.res_valid), 1);
    check("lat_solver", 32'(bus.res_solver), 0);
    repeat (3) cyc();

    // Four back-to-back jobs; core 0 still shows its old done level while reloaded
    for (int j = 0; j < 4; j++) send_job(16'(32'h1001 + j), 6'd1, 16'd200, j);
    check("stale_mask", 32'(bus.res_valid), 0);

    // Fifth header waits until a result frees a core
    bus.job_valid     = 1'b1;
    bus.job_tag       = 16'h1005;
    bus.job_num_limbs = 6'd1;
    bus.job_iter_lim  = 16'd50;
    repeat (3) begin
      @(negedge clock);
      check("full_not_ready", 32'(bus.job_ready), 0);
      cyc();
    end
    finish_core(3, 16'h0333, 16'h1004);
    send_job(16'h1005, 6'd1, 16'd50, 3);

    // Simultaneous done on cores 1 and 3 with rr at 0
    finish_core(1, 16'h0101, 16'h1002);
    finish_core(3, 16'h0303, 16'h1005);
    @(negedge clock);
    check("rr_c0_valid", 32'(bus.res_valid), 0);
    cyc();
    @(negedge clock);
    check("rr_c1", 32'({bus.res_valid, bus.res_solver}), 32'({1'b1, 2'd1}));
    cyc();
    @(negedge clock);
    check("rr_c2", 32'({bus.res_valid, bus.res_solver}), 32'({1'b1, 2'd3}));
    cyc();
    @(negedge clock);
    check("rr_c3_valid", 32'(bus.res_valid), 0);
    cyc();

    // rr wrapped to 0: core 0 wins over core 2
    finish_core(0, 16'h0010, 16'h1001);
    finish_core(2, 16'h0020, 16'h1003);
    cyc();
    @(negedge clock);
    check("rr_wrap_first", 32'(bus.res_solver), 0);
    cyc();
    @(negedge clock);
    check("rr_wrap_second", 32'(bus.res_solver), 2);
    repeat (3) cyc();

    // Backpressure: held result frozen while dispatch continues
    bus.res_ready = 1'b0;
    send_job(16'h2001, 6'd1, 16'hFFFF, 0);
    send_job(16'h2002, 6'd1, 16'd300, 1);
    finish_core(0, 16'hFFFF, 16'h2001);
    finish_core(1, 16'h0011, 16'h2002);
    cyc();
    @(negedge clock);
    check("hold_a_res", 32'({bus.res_valid, bus.res_solver, bus.res_iter}), 32'({1'b1, 2'd0, 16'hFFFF}));
    check("hold_a_tag", 32'(bus.res_tag), 32'h2001);
    cyc();
    // core 0 is free again although its result is still held
    send_job(16'h2003, 6'd1, 16'd77, 0);
    @(negedge clock);
    check("hold_b_res", 32'({bus.res_valid, bus.res_solver, bus.res_iter}), 32'({1'b1, 2'd0, 16'hFFFF}));
    check("hold_b_tag", 32'(bus.res_tag), 32'h2001);
    cyc();
    bus.res_ready = 1'b1;
    finish_core(0, 16'd7, 16'h2003);
    repeat (5) cyc();

    // Zero-limb job, then reset in the middle of a load
    send_job(16'h3003, 6'd0, 16'd9, 0);
    bus.job_valid     = 1'b1;
    bus.job_tag       = 16'h4004;
    bus.job_num_limbs = 6'd3;
    bus.job_iter_lim  = 16'd5;
    @(negedge clock);
    check("mid_accept", 32'(bus.job_ready), 1);
    cyc();
    bus.job_valid  = 1'b0;
    bus.limb_valid = 1'b1;
    repeat (4) cyc();
    @(negedge clock);
    check("mid_im_strobe", 32'(slv_wr_imag_en), 32'(4'b0010));
    check("mid_im_ind", 32'(slv_wr_ind), 1);
    reset = 1'b1;
    #1;
    check("rst_mid_job_ready", 32'(bus.job_ready), 1);
    check("rst_mid_limb_ready", 32'(bus.limb_ready), 0);
    check("rst_mid_strobes", all_strobes(), 0);
    check("rst_mid_ind", 32'(slv_wr_ind), 0);
    check("rst_mid_res", 32'({bus.res_valid, bus.res_solver, bus.res_iter}), 0);
    slv_out_ready  = '0;
    bus.limb_valid = 1'b0;
    cyc();
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_job_ready", 32'(bus.job_ready), 1);
    check("post_rst_strobes", all_strobes(), 0);
    cyc();
    send_job(16'h5005, 6'd1, 16'd12, 0);
    finish_core(0, 16'd3, 16'h5005);

    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      cyc();
      w++;
    end
    check("drain_empty", 32'(exp_q.size()), 0);
    repeat (2) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/solver_scheduler.md
# solver_scheduler

Parametrised job dispatcher that sits above `NUM_SOLVERS` limb-serial solver cores, each built around its own solver_control. It accepts point jobs (tag, limb count, iteration limit, c limbs) on a valid/ready stream and loads each job into the lowest-indexed idle core. It then starts that core and returns `(tag, iteration count, core index)` results on a second valid/ready stream, arbitrated round-robin. Raw limb data is broadcast to all cores by the top level; this block drives only the per-core write strobes, indices, configuration and start.

## Interface
- `NUM_SOLVERS`, 4: number of solver cores (1..16).
- `LIMB_INDEX_BITS`, 6: limb index / limb count width.
- `ITER_BITS`, 16: iteration limit/count width.
- `TAG_BITS`, 16: opaque job tag width.
- `SEL_BITS`, $clog2(NUM_SOLVERS) (min 1): core index width.

- `clock`  in  1  sole clock; all state on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `job_valid`  in  1  job header offered.
- `job_ready`  out  1  header accepted this cycle.
- `job_tag`  in  TAG_BITS  job tag.
- `job_num_limbs`  in  LIMB_INDEX_BITS  limbs per component.
- `job_iter_lim`  in  ITER_BITS  iteration limit.
- `limb_valid`  in  1  limb beat offered (data on top-level broadcast bus).
- `limb_ready`  out  1  limb beat consumed.
- `slv_wr_real_en`  out  NUM_SOLVERS  one-hot real-limb write strobe.
- `slv_wr_imag_en`  out  NUM_SOLVERS  one-hot imag-limb write strobe.
- `slv_wr_ind`  out  LIMB_INDEX_BITS  limb index, shared by all cores.
- `slv_wr_num_limbs_en`  out  NUM_SOLVERS  one-hot config strobe.
- `slv_wr_iter_lim_en`  out  NUM_SOLVERS  one-hot config strobe.
- `slv_num_limbs`  out  LIMB_INDEX_BITS  config data, shared.
- `slv_iter_lim`  out  ITER_BITS  config data, shared.
- `slv_start`  out  NUM_SOLVERS  one-hot start pulse.
- `slv_out_ready`  in  NUM_SOLVERS  per-core done level.
- `slv_iter_count`  in  NUM_SOLVERS*ITER_BITS  per-core count; core k occupies bits [k*ITER_BITS +: ITER_BITS].
- `res_valid`  out  1  result held.
- `res_ready`  in  1  result consumed.
- `res_tag`  out  TAG_BITS  result tag.
- `res_iter`  out  ITER_BITS  iteration count; all-ones means the limit was reached, passed through unchanged.
- `res_solver`  out  SEL_BITS  producing core.

## Operation
- Per-core registers:
  - `busy[k]`: set at the edge ending START.
  - `armed[k]`: set at that same edge.
  - `tag[k]`: latched at header acceptance.
- Core k is free when `busy[k]==0`.
- Dispatch FSM, states IDLE, LOAD_RE, LOAD_IM, CONFIG, START:
  - IDLE: `job_ready` = any core free (combinational from registered busy). On `job_valid && job_ready`:
    - latch `sel` = lowest free index, plus `tag`, `num_limbs` and `iter_lim`;
    - go to LOAD_RE, or to CONFIG if `job_num_limbs==0`.
  - LOAD_RE: `limb_ready=1`; `slv_wr_ind` = beat counter i (0..n-1).
    - `slv_wr_real_en[sel] = limb_valid`; i increments per beat.
    - After beat n-1, go to LOAD_IM with i=0.
  - LOAD_IM: same as LOAD_RE using `slv_wr_imag_en`; after beat n-1, go to CONFIG.
  - CONFIG (1 cycle): `slv_wr_num_limbs_en[sel]=slv_wr_iter_lim_en[sel]=1` with latched values; go to START. Config precedes start by exactly one cycle because the core samples the limb count on its start cycle.
  - START (1 cycle): `slv_start[sel]=1`; set `busy[sel]` and `armed[sel]`; go to IDLE.
- Strobe behaviour:
  - All strobes are 0 outside their state.
  - `limb_ready=0` outside LOAD_RE/LOAD_IM.
  - `slv_wr_ind`, `slv_num_limbs` and `slv_iter_lim` are don't-care when their strobes are low.
- Completion: `done[k] = armed[k] && slv_out_ready[k]`. A core's done level from its previous job is masked, because its out_ready falls at the same edge where armed rises.
- Result capture happens when the result register is empty or is handed off this cycle (`!res_valid || res_ready`) and any done:
  - pick the first done core at or after the round-robin pointer `rr`;
  - load `res_tag`, `res_iter`, `res_solver`; set `res_valid`;
  - clear `busy` and `armed` for that core; set `rr = picked+1` (mod N).
- Handoff without a new capture clears `res_valid`.
- `res_*` are stable while `res_valid && !res_ready`.

## Timing
- Reset (async): state IDLE; busy, armed, rr, counters and `res_valid` = 0; every output = 0, except `job_ready`, which is 1 immediately after reset (all cores free).
- Job overhead: header cycle + 2n beat cycles (at full `limb_valid`) + CONFIG + START. The next header is acceptable in the cycle after START.
- Done → `res_valid`: 1 cycle (registered). Throughput is 1 result per cycle under continuous `res_ready`.
- A captured core is free from the next cycle and may be re-dispatched while its result is still in `res_*`.
- A core finishing in the same cycle as another core's START is captured normally. START of core k never matches done[k] in the same cycle.
- Reset mid-load or mid-run abandons all jobs. Cores share the reset; no results are emitted for abandoned jobs.

## Test plan
- NUM_SOLVERS=4, one job (tag 0x0A5A, n=2, lim 100), full `limb_valid`:
  - strobes: real idx 0,1 → imag idx 0,1 → config → `slv_start=4'b0001`;
  - core 0 done with count 37 → `res_valid` next cycle, tag 0x0A5A, iter 37, solver 0.
- Four back-to-back jobs → starts on cores 0,1,2,3 in order; a fifth header sees `job_ready=0` until a result is captured, then dispatches to the freed core.
- Cores 1 and 3 done simultaneously, rr=0, `res_ready=1` → core 1 result, then core 3 the next cycle; rr ends at 0.
- Stale done: core 0 holds `slv_out_ready=1` from a prior job while restarted → no result until it drops and rises again.
- `res_ready=0` for 5 cycles with results pending → `res_*` frozen; other cores' dispatch continues; core whose count is all-ones → `res_iter=16'hFFFF`.
- `job_num_limbs=0` → LOAD states skipped; config then start follow the header; assert reset during LOAD_IM → all outputs 0, `job_ready=1` after release.
